// File: rtl/mux_n_scan.sv
// N-channel registered mux: manual select or timed round-robin scan.
// Every output is registered; scan position restarts at channel 0 on manual/reset.
module mux_n_scan #(
   parameter int WIDTH = 8,
   parameter int CH    = 4,
   parameter int DWELL = 4,
   localparam int SELW = (CH > 2) ? $clog2(CH) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CH*WIDTH-1:0] din,
   input  logic [SELW-1:0]     sel,
   input  logic                mode,
   input  logic                en,
   output logic [WIDTH-1:0]    dout,
   output logic [SELW-1:0]     ch_out,
   output logic                vld,
   output logic                wrap
);

   localparam int CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [SELW:0]   CH_W   = (SELW+1)'(CH);
   localparam logic [SELW-1:0] PTR_LAST = SELW'(CH - 1);
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);

   logic [SELW-1:0]  ptr;
   logic [CNTW-1:0]  cnt;
   logic [WIDTH-1:0] man_data;
   logic [WIDTH-1:0] scan_data;
   logic             sel_ok;
   logic             cnt_last;
   logic             ptr_last;

   // Loop mux keeps out-of-range selects from ever indexing past din.
   always_comb begin
      man_data  = '0;
      scan_data = '0;
      for (int k = 0; k < CH; k++) begin
         if (sel == SELW'(k)) man_data  = din[k*WIDTH +: WIDTH];
         if (ptr == SELW'(k)) scan_data = din[k*WIDTH +: WIDTH];
      end
   end

   assign sel_ok   = {1'b0, sel} < CH_W;
   assign cnt_last = (cnt == CNT_LAST);
   assign ptr_last = (ptr == PTR_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         dout   <= '0;
         ch_out <= '0;
         vld    <= 1'b0;
         wrap   <= 1'b0;
         ptr    <= '0;
         cnt    <= '0;
      end else begin
         vld  <= 1'b0;
         wrap <= 1'b0;
         if (!mode) begin
            ptr <= '0;
            cnt <= '0;
         end
         if (en) begin
            if (!mode) begin
               if (sel_ok) begin
                  dout   <= man_data;
                  ch_out <= sel;
                  vld    <= 1'b1;
               end
            end else begin
               dout   <= scan_data;
               ch_out <= ptr;
               vld    <= 1'b1;
               if (cnt_last) begin
                  cnt  <= '0;
                  ptr  <= ptr_last ? '0 : ptr + 1'b1;
                  wrap <= ptr_last;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_mux_n_scan.sv
// Directed bench for mux_n_scan: reset, manual, scan, enable gaps,
// mid-scan reset, mode switching, CH=3 illegal select and DWELL=1 scan.
module tb_mux_n_scan;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] din;
   logic [1:0]  sel;
   logic        mode;
   logic        en;

   logic [7:0]  dout,  dout3,  dout1;
   logic [1:0]  ch_out, ch3,   ch1;
   logic        vld,   vld3,   vld1;
   logic        wrap,  wrap3,  wrap1;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   mux_n_scan #(.WIDTH(8), .CH(4), .DWELL(2)) u_dut (
      .clk(clk), .rst(rst), .din(din), .sel(sel), .mode(mode), .en(en),
      .dout(dout), .ch_out(ch_out), .vld(vld), .wrap(wrap)
   );

   mux_n_scan #(.WIDTH(8), .CH(3), .DWELL(2)) u_ch3 (
      .clk(clk), .rst(rst), .din(din[23:0]), .sel(sel), .mode(mode),
      .en(en), .dout(dout3), .ch_out(ch3), .vld(vld3), .wrap(wrap3)
   );

   mux_n_scan #(.WIDTH(8), .CH(4), .DWELL(1)) u_dw1 (
      .clk(clk), .rst(rst), .din(din), .sel(sel), .mode(mode), .en(en),
      .dout(dout1), .ch_out(ch1), .vld(vld1), .wrap(wrap1)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [7:0] d,
                             input logic [1:0] c, input logic v,
                             input logic w);
      check({tag, ".dout"}, 32'(dout), 32'(d));
      check({tag, ".ch"},   32'(ch_out), 32'(c));
      check({tag, ".vld"},  32'(vld), 32'(v));
      check({tag, ".wrap"}, 32'(wrap), 32'(w));
   endtask

   logic [7:0] man_exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
   logic [7:0] scan_exp [10] = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33,
                                 8'h33, 8'h44, 8'h44, 8'h11, 8'h11};
   logic [1:0] scan_ch [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
   logic [7:0] dw1_exp [10] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11,
                                8'h22, 8'h33, 8'h44, 8'h11, 8'h22};

   initial begin
      din  = {8'h44, 8'h33, 8'h22, 8'h11};
      rst  = 1'b1;
      en   = 1'b1;
      mode = 1'b1;
      sel  = 2'd2;
      @(negedge clk);
      tick();
      tick();
      expect_out("reset", 8'h00, 2'd0, 1'b0, 1'b0);
      rst = 1'b0;

      mode = 1'b0;
      for (int i = 0; i < 4; i++) begin
         sel = 2'(i);
         tick();
         expect_out($sformatf("man%0d", i), man_exp[i], 2'(i), 1'b1, 1'b0);
      end

      en = 1'b0;
      tick();
      expect_out("man_en0", 8'h44, 2'd3, 1'b0, 1'b0);
      en = 1'b1;

      mode = 1'b1;
      sel  = 2'd3;
      for (int i = 0; i < 10; i++) begin
         tick();
         expect_out($sformatf("scan%0d", i), scan_exp[i], scan_ch[i],
                    1'b1, (i == 7));
         check($sformatf("dw1_dout%0d", i), 32'(dout1), 32'(dw1_exp[i]));
         check($sformatf("dw1_wrap%0d", i), 32'(wrap1),
               32'(i == 3 || i == 7));
      end

      mode = 1'b0;
      sel  = 2'd0;
      tick();
      mode = 1'b1;
      tick();
      tick();
      tick();
      expect_out("gap_first22", 8'h22, 2'd1, 1'b1, 1'b0);
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_out($sformatf("gap_hold%0d", i), 8'h22, 2'd1, 1'b0, 1'b0);
      end
      en = 1'b1;
      tick();
      expect_out("gap_resume22", 8'h22, 2'd1, 1'b1, 1'b0);
      tick();
      expect_out("gap_then33", 8'h33, 2'd2, 1'b1, 1'b0);

      rst = 1'b1;
      tick();
      expect_out("midrst", 8'h00, 2'd0, 1'b0, 1'b0);
      rst = 1'b0;
      tick();
      expect_out("postrst0", 8'h11, 2'd0, 1'b1, 1'b0);
      tick();
      expect_out("postrst1", 8'h11, 2'd0, 1'b1, 1'b0);
      tick();
      expect_out("postrst2", 8'h22, 2'd1, 1'b1, 1'b0);

      mode = 1'b0;
      sel  = 2'd3;
      tick();
      expect_out("switch_man", 8'h44, 2'd3, 1'b1, 1'b0);
      mode = 1'b1;
      tick();
      expect_out("switch_scan", 8'h11, 2'd0, 1'b1, 1'b0);

      mode = 1'b0;
      sel  = 2'd2;
      tick();
      check("ch3_sel2.dout", 32'(dout3), 32'h33);
      check("ch3_sel2.vld",  32'(vld3), 32'd1);
      sel = 2'd3;
      tick();
      check("ch3_sel3.dout", 32'(dout3), 32'h33);
      check("ch3_sel3.ch",   32'(ch3), 32'd2);
      check("ch3_sel3.vld",  32'(vld3), 32'd0);
      check("ch3_sel3.wrap", 32'(wrap3), 32'd0);
      expect_out("ch4_sel3", 8'h44, 2'd3, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
